mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/cu_decode.sv | 56 +++++
 rtl/mc_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I control constants: FSM state encoding, ALU/PC-select codes, opcodes.
// The optional trap path (macro CU_TRAP_EN) reuses ST_TRAP; the default build never enters it.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } cu_state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_ITYPE = 3'b011,
        ALU_PASSB = 3'b100,
        ALU_AUIPC = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_JALR   = 2'b10,
        PC_TRAP   = 2'b11
    } pc_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ADDI x0,x0,0: the IR holds this after reset so nothing retires spuriously.
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    is_load;
        logic    is_store;
        logic    is_branch;
        logic    is_jal;
        logic    is_jalr;
        logic    illegal;
    } decode_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: ALU operation, operand-B source and instruction class.
module cu_decode
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can infer a latch.
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_op = ALU_RTYPE;
            end
            OPC_OP_IMM: begin
                dec.alu_op  = ALU_ITYPE;
                dec.alu_src = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op  = ALU_PASSB;
                dec.alu_src = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op  = ALU_AUIPC;
                dec.alu_src = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_src = 1'b1;
                dec.is_jal  = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_src = 1'b1;
                dec.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src = 1'b1;
                dec.is_load = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_src  = 1'b1;
                dec.is_store = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with retired count.
// Define CU_TRAP_EN to add the TRAP state (illegal opcodes, ack timeouts beyond MEM_TIMEOUT).
module mc_control_unit
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             take_branch,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [4:0]       rd,
    output logic [2:0]       aluOp,
    output logic             aluSrc,
    output logic             memToReg,
    output logic             regWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSel,
    output logic [2:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] instret
);

    cu_state_e        state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    decode_t          dec;

    logic    imem_req_s;
    alu_op_e alu_op_s;
    pc_sel_e pc_sel_s;

    cu_decode u_decode (
        .opcode (ir_q[6:0]),
        .dec    (dec)
    );

`ifdef CU_TRAP_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout;

    // Asserted on the (MEM_TIMEOUT+1)-th consecutive cycle without an ack.
    assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT));
`else
    localparam int UNUSED_MEM_TIMEOUT = MEM_TIMEOUT;
`endif

    // Immediate bits are consumed by the datapath, not by the sequencer.
    logic unused_ir_hi;
    assign unused_ir_hi = ^ir_q[31:15];

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imem_req_s = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        regWrite   = 1'b0;
        memToReg   = 1'b0;
        pcWrite    = 1'b0;
        pc_sel_s   = PC_PLUS4;
        alu_op_s   = ALU_ADD;
        aluSrc     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
`ifdef CU_TRAP_EN
                else if (timeout) begin
                    state_d = ST_TRAP;
                end
`endif
            end
            ST_DECODE: begin
`ifdef CU_TRAP_EN
                state_d = dec.illegal ? ST_TRAP : ST_EXEC;
`else
                state_d = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                alu_op_s = dec.alu_op;
                aluSrc   = dec.alu_src;
                if (dec.is_load || dec.is_store) begin
                    state_d = ST_MEM;
                end else if (dec.is_branch) begin
                    pcWrite  = 1'b1;
                    pc_sel_s = take_branch ? PC_TARGET : PC_PLUS4;
                    state_d  = ST_FETCH;
                end else if (dec.illegal) begin
                    // Illegal opcodes retire as NOPs when there is no trap path.
                    pcWrite = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec.is_store;
                if (dmem_ack) begin
                    if (dec.is_store) begin
                        pcWrite = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
`ifdef CU_TRAP_EN
                else if (timeout) begin
                    state_d = ST_TRAP;
                end
`endif
            end
            ST_WB: begin
                regWrite = (ir_q[11:7] != 5'd0);
                memToReg = dec.is_load;
                pcWrite  = 1'b1;
                if (dec.is_jal) begin
                    pc_sel_s = PC_TARGET;
                end else if (dec.is_jalr) begin
                    pc_sel_s = PC_JALR;
                end
                state_d = ST_FETCH;
            end
`ifdef CU_TRAP_EN
            ST_TRAP: begin
                pcWrite  = 1'b1;
                pc_sel_s = PC_TRAP;
                state_d  = ST_FETCH;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        instret_d = instret_q;
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_TRAP) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

`ifdef CU_TRAP_EN
    always_comb begin
        wait_d = '0;
        if ((state_q == ST_FETCH || state_q == ST_MEM) && state_d == state_q) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= INSN_NOP;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    // The fetch strobe is gated so it stays low for the whole reset pulse.
    assign imem_req = imem_req_s & ~reset;
    assign aluOp    = alu_op_s;
    assign pcSel    = pc_sel_s;
    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign rd       = ir_q[11:7];
    assign state    = state_q;
    assign busy     = (state_q != ST_FETCH);
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed RV32I cases plus randomized
// instruction streams with random ack delays, checked cycle by cycle against a timeline model.
module tb_mc_control_unit;
    import rv32i_pkg::*;

    localparam int TMO = 15;
    localparam int CW  = 4;

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_TRAP   = ST_TRAP;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req, imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic          take_branch;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic [2:0]    aluOp;
    logic          aluSrc, memToReg, regWrite, pcWrite;
    logic [1:0]    pcSel;
    logic [2:0]    state;
    logic          busy;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .take_branch (take_branch),
        .opcode      (opcode),
        .funct3      (funct3),
        .rd          (rd),
        .aluOp       (aluOp),
        .aluSrc      (aluSrc),
        .memToReg    (memToReg),
        .regWrite    (regWrite),
        .pcWrite     (pcWrite),
        .pcSel       (pcSel),
        .state       (state),
        .busy        (busy),
        .instret     (instret)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Architectural model: the instruction the control unit should be holding and
    // how many instructions have retired (wraps at 2^CW like the real counter).
    logic [31:0]   ir_m    = 32'h0000_0013;
    logic [CW-1:0] retired = '0;

    typedef enum int {C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_ILL} cls_e;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       chk_we;
        logic       we;
        logic       chk_m2r;
        logic       m2r;
        logic       chk_alu;
        logic [3:0] alu;
    } exp_t;

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            default:    return C_ILL;
        endcase
    endfunction

    // {aluOp, aluSrc} expected in EXEC for each instruction class.
    function automatic logic [3:0] alu_exp(input cls_e c);
        case (c)
            C_R:     return 4'b010_0;
            C_I:     return 4'b011_1;
            C_LUI:   return 4'b100_1;
            C_AUIPC: return 4'b101_1;
            C_BR:    return 4'b001_0;
            default: return 4'b000_1;
        endcase
    endfunction

    function automatic exp_t idle(input logic [2:0] st);
        exp_t e;
        e          = '0;
        e.state    = st;
        e.imem_req = (st == S_FETCH);
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs at the falling edge, then compare outputs.
    task automatic step(input exp_t e, input logic i_ack, input logic d_ack,
                        input logic tkn, input logic [31:0] rdata, input string name);
        logic [26:0] got, want;
        @(negedge clk);
        imem_ack    = i_ack;
        dmem_ack    = d_ack;
        take_branch = tkn;
        imem_rdata  = rdata;
        #1;
        got  = {state, busy, imem_req, dmem_req, regWrite, pcWrite, instret,
                funct3, rd, opcode};
        want = {e.state, (e.state != S_FETCH), e.imem_req, e.dmem_req, e.reg_write,
                e.pc_write, retired, ir_m[14:12], ir_m[11:7], ir_m[6:0]};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s core: got %h want %h (st/busy/ireq/dreq/rw/pw/instret/f3/rd/op)",
                     name, got, want);
        end
        if (e.pc_write) begin
            vectors++;
            if (pcSel !== e.pc_sel) begin
                miscompares++;
                $display("FAIL %s pcSel: got %b want %b", name, pcSel, e.pc_sel);
            end
        end
`ifndef CU_TRAP_EN
        vectors++;
        if (pcSel === 2'b11) begin
            miscompares++;
            $display("FAIL %s pcSel_trap_code: got %b want not 11", name, pcSel);
        end
`endif
        if (e.chk_we) begin
            vectors++;
            if (dmem_we !== e.we) begin
                miscompares++;
                $display("FAIL %s dmem_we: got %b want %b", name, dmem_we, e.we);
            end
        end
        if (e.chk_m2r) begin
            vectors++;
            if (memToReg !== e.m2r) begin
                miscompares++;
                $display("FAIL %s memToReg: got %b want %b", name, memToReg, e.m2r);
            end
        end
        if (e.chk_alu) begin
            vectors++;
            if ({aluOp, aluSrc} !== e.alu) begin
                miscompares++;
                $display("FAIL %s aluOp/aluSrc: got %b want %b", name, {aluOp, aluSrc}, e.alu);
            end
        end
    endtask

    // Runs one instruction from FETCH back to FETCH. di/dd: cycles before imem/dmem ack.
    task automatic run_instr(input logic [31:0] instr, input int di, input int dd,
                             input logic tkn, input string name);
        cls_e c;
        exp_t e;
        c = classify(instr[6:0]);
        for (int i = 0; i <= di; i++) begin
            e = idle(S_FETCH);
            step(e, (i == di), rb(), rb(), instr, name);
        end
        ir_m = instr;
        e = idle(S_DECODE);
        step(e, rb(), rb(), rb(), $urandom, name);
`ifdef CU_TRAP_EN
        if (c == C_ILL) begin
            e          = idle(S_TRAP);
            e.pc_write = 1'b1;
            e.pc_sel   = 2'b11;
            step(e, rb(), rb(), rb(), $urandom, name);
            return;
        end
`endif
        e = idle(S_EXEC);
        if (c != C_ILL) begin
            e.chk_alu = 1'b1;
            e.alu     = alu_exp(c);
        end
        if (c == C_BR || c == C_ILL) begin
            e.pc_write = 1'b1;
            e.pc_sel   = (c == C_BR && tkn) ? 2'b01 : 2'b00;
        end
        step(e, rb(), rb(), tkn, $urandom, name);
        if (c == C_BR || c == C_ILL) begin
            retired++;
            return;
        end
        if (c == C_LD || c == C_ST) begin
            for (int j = 0; j <= dd; j++) begin
                e          = idle(S_MEM);
                e.dmem_req = 1'b1;
                e.chk_we   = 1'b1;
                e.we       = (c == C_ST);
                if (c == C_ST && j == dd) e.pc_write = 1'b1;
                step(e, rb(), (j == dd), rb(), $urandom, name);
            end
            if (c == C_ST) begin
                retired++;
                return;
            end
        end
        e           = idle(S_WB);
        e.reg_write = (instr[11:7] != 5'd0);
        e.chk_m2r   = 1'b1;
        e.m2r       = (c == C_LD);
        e.pc_write  = 1'b1;
        e.pc_sel    = (c == C_JAL) ? 2'b01 : (c == C_JALR) ? 2'b10 : 2'b00;
        step(e, rb(), rb(), rb(), $urandom, name);
        retired++;
    endtask

    task automatic check_reset_outputs(input string name);
        logic [22:0] got, want;
        got  = {state, imem_req, dmem_req, regWrite, pcWrite, instret, funct3, rd, opcode};
        want = {S_FETCH, 4'b0000, {CW{1'b0}}, 3'd0, 5'd0, 7'b0010011};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (st/ireq/dreq/rw/pw/instret/f3/rd/op)",
                     name, got, want);
        end
    endtask

    task automatic check_first_fetch(input string name);
        vectors++;
        if ({state, imem_req, busy} !== {S_FETCH, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL %s: got st=%0d ireq=%b busy=%b want st=0 ireq=1 busy=0",
                     name, state, imem_req, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #13;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_first_fetch("first_fetch_after_reset");
        ir_m    = 32'h0000_0013;
        retired = '0;
    endtask

    task automatic test_alu();
        run_instr(32'h0000_07B3, 0, 0, 1'b0, "add_x15");
        run_instr(32'h0000_0033, 0, 0, 1'b0, "add_x0_no_regwrite");
        run_instr(32'h0050_8093, 2, 0, 1'b1, "addi_x1");
        run_instr(32'h0001_22B7, 0, 0, 1'b0, "lui_x5");
        run_instr(32'h0000_1317, 1, 0, 1'b0, "auipc_x6");
    endtask

    task automatic test_jumps();
        run_instr(32'h0080_00EF, 0, 0, 1'b0, "jal_x1");
        run_instr(32'h0000_8067, 0, 0, 1'b1, "jalr_x0");
    endtask

    task automatic test_load_store();
        run_instr(32'h0001_2083, 0, 3, 1'b0, "lw_ack_delay3");
        run_instr(32'h0001_2083, 0, 0, 1'b0, "lw_zero_wait");
        run_instr(32'h0011_2223, 0, 0, 1'b0, "sw_zero_wait");
        run_instr(32'h0011_2223, 1, 2, 1'b1, "sw_ack_delay2");
    endtask

    task automatic test_branch();
        run_instr(32'h0000_0463, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h0000_0463, 0, 0, 1'b0, "beq_not_taken");
    endtask

    task automatic test_illegal();
        run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, "illegal_ffffffff");
        run_instr(32'h0000_0073, 0, 0, 1'b0, "illegal_system");
    endtask

    task automatic test_wait_limits();
`ifdef CU_TRAP_EN
        exp_t e;
        run_instr(32'h0000_07B3, TMO, 0, 1'b0, "fetch_wait_at_limit");
        run_instr(32'h0001_2083, 0, TMO, 1'b0, "load_wait_at_limit");
        for (int i = 0; i <= TMO; i++) begin
            e = idle(S_FETCH);
            step(e, 1'b0, rb(), rb(), $urandom, "fetch_timeout");
        end
        e          = idle(S_TRAP);
        e.pc_write = 1'b1;
        e.pc_sel   = 2'b11;
        step(e, rb(), rb(), rb(), $urandom, "fetch_timeout_trap");
        e = idle(S_FETCH);
        step(e, 1'b1, 1'b0, 1'b0, 32'h0011_2223, "mem_timeout");
        ir_m = 32'h0011_2223;
        step(idle(S_DECODE), rb(), rb(), rb(), $urandom, "mem_timeout");
        e         = idle(S_EXEC);
        e.chk_alu = 1'b1;
        e.alu     = 4'b000_1;
        step(e, rb(), rb(), rb(), $urandom, "mem_timeout");
        for (int j = 0; j <= TMO; j++) begin
            e          = idle(S_MEM);
            e.dmem_req = 1'b1;
            e.chk_we   = 1'b1;
            e.we       = 1'b1;
            step(e, rb(), 1'b0, rb(), $urandom, "mem_timeout");
        end
        e          = idle(S_TRAP);
        e.pc_write = 1'b1;
        e.pc_sel   = 2'b11;
        step(e, rb(), rb(), rb(), $urandom, "mem_timeout_trap");
`else
        run_instr(32'h0000_07B3, 40, 0, 1'b0, "fetch_long_wait");
        run_instr(32'h0001_2083, 0, 40, 1'b0, "load_long_wait");
`endif
    endtask

    task automatic test_reset_mid_mem();
        exp_t e;
        e = idle(S_FETCH);
        step(e, 1'b1, 1'b0, 1'b0, 32'h0001_2083, "reset_mid_mem");
        ir_m = 32'h0001_2083;
        step(idle(S_DECODE), 1'b0, 1'b0, 1'b0, $urandom, "reset_mid_mem");
        e         = idle(S_EXEC);
        e.chk_alu = 1'b1;
        e.alu     = 4'b000_1;
        step(e, 1'b0, 1'b0, 1'b0, $urandom, "reset_mid_mem");
        for (int j = 0; j < 2; j++) begin
            e          = idle(S_MEM);
            e.dmem_req = 1'b1;
            e.chk_we   = 1'b1;
            step(e, 1'b0, 1'b0, 1'b0, $urandom, "reset_mid_mem");
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_mem_async");
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        ir_m    = 32'h0000_0013;
        retired = '0;
        check_first_fetch("first_fetch_after_mid_reset");
    endtask

    task automatic test_random();
        logic [6:0]  ops [9];
        logic [31:0] instr;
        int          pick;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            pick  = $urandom_range(0, 9);
            if (pick < 9) instr[6:0] = ops[pick];
            run_instr(instr, $urandom_range(0, 4), $urandom_range(0, 4), rb(), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        take_branch = 1'b0;
        imem_rdata  = 32'h0;
        test_reset();
        test_alu();
        test_jumps();
        test_load_store();
        test_branch();
        test_illegal();
        test_wait_limits();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
